// File: rtl/loader_pkg.sv
// Shared types and sizes for the program loader.
package loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned WORD_W     = BYTE_W * WORD_BYTES;
    localparam int unsigned LANE_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/word_packer.sv
// Inserts one stream byte into its little-endian lane of a word.
// Lane 0 starts a fresh word, so lanes not yet received read as zero.
module word_packer
    import loader_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [LANE_W-1:0] lane,
    input  logic [BYTE_W-1:0] data,
    output logic [WORD_W-1:0] packed_c
);

    // Clear on lane 0, then overwrite the addressed lane.
    always_comb begin
        packed_c = (lane == '0) ? '0 : word;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (lane == LANE_W'(i)) begin
                packed_c[BYTE_W*i +: BYTE_W] = data;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed byte image into word-wide program memory.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MEM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] byte_address,
    output logic        write_enable,
    output logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned LEN_LIMIT = MEM_BYTES - BASE_ADDR;

    state_t              state;
    logic [31:0]         len;
    logic [31:0]         count;
    logic [WORD_W-1:0]   word_acc;
    logic [LANE_W-1:0]   hdr_cnt;

    logic                fire_c;
    logic                last_c;
    logic                word_end_c;
    logic [WORD_W-1:0]   pack_word_c;
    logic [LANE_W-1:0]   pack_lane_c;
    logic [WORD_W-1:0]   packed_c;

    // Shared packer: header bytes build the length, payload bytes build words.
    always_comb begin
        fire_c      = in_valid && in_ready;
        last_c      = (count == len - 32'd1);
        word_end_c  = (count[LANE_W-1:0] == LANE_W'(WORD_BYTES - 1));
        pack_word_c = (state == HDR) ? len : word_acc;
        pack_lane_c = (state == HDR) ? hdr_cnt : count[LANE_W-1:0];
    end

    word_packer u_word_packer (
        .word     (pack_word_c),
        .lane     (pack_lane_c),
        .data     (in_data),
        .packed_c (packed_c)
    );

    // Load sequencer with registered handshake, status and write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            len          <= '0;
            count        <= '0;
            word_acc     <= '0;
            hdr_cnt      <= '0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            write_enable <= 1'b0;
            byte_address <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= HDR;
                        len      <= '0;
                        count    <= '0;
                        hdr_cnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                HDR: begin
                    if (fire_c) begin
                        len     <= packed_c;
                        hdr_cnt <= hdr_cnt + LANE_W'(1);
                        if (hdr_cnt == LANE_W'(HDR_BYTES - 1)) begin
                            if (packed_c == '0) begin
                                state    <= DONE;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                            end else if (packed_c > LEN_LIMIT) begin
                                state    <= ERR;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                error    <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (fire_c) begin
                        word_acc <= packed_c;
                        count    <= count + 32'd1;
                        if (word_end_c || last_c) begin
                            write_enable <= 1'b1;
                            byte_address <= 32'(BASE_ADDR) + {count[31:LANE_W], LANE_W'(0)};
                            write_data   <= packed_c;
                        end
                        if (last_c) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard.
module tb_program_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] byte_address;
    logic        write_enable;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    // Expected writes {addr, data}, pushed as stimulus is planned.
    logic [63:0] exp_q[$];

    // Observed writes, recorded by the monitor only.
    logic [31:0] obs_addr [64];
    logic [31:0] obs_data [64];
    logic        obs_done [64];
    int          obs_n = 0;
    int          rd    = 0;

    program_loader #(.BASE_ADDR(0), .MEM_BYTES(2048)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .byte_address (byte_address),
        .write_enable (write_enable),
        .write_data   (write_data),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe shortly after the active edge.
    always @(posedge clk) begin
        #1;
        if (write_enable === 1'b1) begin
            if (obs_n < 64) begin
                obs_addr[obs_n] = byte_address;
                obs_data[obs_n] = write_data;
                obs_done[obs_n] = done;
            end
            obs_n = obs_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_bytes(input byte_q_t b, input int max_gap);
        for (int i = 0; i < b.size(); i++) begin
            int gap;
            int w;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
            in_valid = 1'b1;
            in_data  = b[i];
            w = 0;
            while (in_ready !== 1'b1 && w < 16) begin
                @(negedge clk);
                w++;
            end
            if (in_ready !== 1'b1) chk("ready_wait", 64'(in_ready), 64'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Compare all writes since the last call against the expected queue.
    task automatic compare_writes(input string tag, input logic expect_done_last);
        logic [63:0] e;
        int          last;
        chk($sformatf("%s_count", tag), 64'(obs_n - rd), 64'(exp_q.size()));
        last = -1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd < obs_n && rd < 64) begin
                chk($sformatf("%s_write%0d", tag, rd), {obs_addr[rd], obs_data[rd]}, e);
                last = rd;
                rd++;
            end
        end
        if (expect_done_last && last >= 0)
            chk($sformatf("%s_done_with_last_write", tag), 64'(obs_done[last]), 64'd1);
        rd = obs_n;
    endtask

    task automatic check_idle_zero(input string tag);
        chk($sformatf("%s_flags", tag),
            64'({in_ready, busy, done, error, write_enable}), 64'd0);
        chk($sformatf("%s_addr_data", tag), {byte_address, write_data}, 64'd0);
    endtask

    initial begin
        byte_q_t q;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Two full words, back-to-back bytes.
        pulse_start();
        chk("t1_busy_ready", 64'({busy, in_ready, done, error}), 64'b1100);
        exp_q.push_back({32'h0, 32'h0000_0013});
        exp_q.push_back({32'h4, 32'h0020_0093});
        q = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
        send_bytes(q, 0);
        repeat (2) @(negedge clk);
        compare_writes("t1", 1'b1);
        chk("t1_status", 64'({busy, in_ready, done, error}), 64'b0010);

        // Partial final word is zero-filled, random gaps.
        pulse_start();
        chk("t2_done_cleared", 64'({busy, done}), 64'b10);
        exp_q.push_back({32'h0, 32'h0000_0013});
        exp_q.push_back({32'h4, 32'h0000_4529});
        q = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h29, 8'h45};
        send_bytes(q, 3);
        repeat (3) @(negedge clk);
        compare_writes("t2", 1'b1);
        chk("t2_status", 64'({busy, in_ready, done, error}), 64'b0010);

        // Zero-length header completes with no writes.
        pulse_start();
        q = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_bytes(q, 0);
        chk("t3_status", 64'({busy, in_ready, done, error}), 64'b0010);
        repeat (2) @(negedge clk);
        compare_writes("t3", 1'b0);

        // Oversized length goes to error; a new start re-enters the header.
        pulse_start();
        q = '{8'h00, 8'h10, 8'h00, 8'h00};
        send_bytes(q, 0);
        chk("t4_status", 64'({busy, in_ready, done, error}), 64'b0001);
        repeat (3) @(negedge clk);
        chk("t4_error_held", 64'({in_ready, error}), 64'b01);
        compare_writes("t4", 1'b0);
        pulse_start();
        chk("t4_restart", 64'({busy, in_ready, done, error}), 64'b1100);

        // Reset mid-payload aborts after the first word.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_zero("t5_pre");
        pulse_start();
        exp_q.push_back({32'h0, 32'h4433_2211});
        q = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_bytes(q, 4);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check_idle_zero("t5_post");
        repeat (3) @(negedge clk);
        compare_writes("t5", 1'b0);
        check_idle_zero("t5_idle");

        // Start during payload is ignored.
        pulse_start();
        exp_q.push_back({32'h0, 32'h0403_0201});
        exp_q.push_back({32'h4, 32'h0807_0605});
        q = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
        send_bytes(q, 0);
        pulse_start();
        chk("t6_start_ignored", 64'({busy, in_ready, done, error}), 64'b1100);
        q = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_bytes(q, 2);
        repeat (2) @(negedge clk);
        compare_writes("t6", 1'b1);
        chk("t6_status", 64'({busy, in_ready, done, error}), 64'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
